clock_divider_nch: RTL and testbench

CLOCK_DIVIDER_NCH -- requirements
Module: clock_divider_nch

---
 rtl/clkdiv_pkg.sv | 19 +
 rtl/clkdiv_channel.sv | 100 ++++++++++
 rtl/clock_divider_nch.sv | 74 +++++++
 tb/tb_clock_divider_nch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants, default channel configuration type and reset-value helper
// for clock_divider_nch.
package clkdiv_pkg;

   localparam int CLKDIV_DEF_NCH = 4;
   localparam int CLKDIV_DEF_CW  = 32;
   localparam int CLKDIV_DEF_DIV = 2;

   // Default-width form; the top rebuilds the same shape at its own CW.
   typedef struct packed {
      logic [CLKDIV_DEF_CW-1:0] div;
      logic [CLKDIV_DEF_CW-1:0] high;
   } clkdiv_cfg_t;

   function automatic int clkdiv_def_high(input int div);
      return (div / 2 < 1) ? 1 : div / 2;
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending (div, high) pairs and
// registered clk_out/tick. Optional phase alignment under CLKDIV_SYNC_ALIGN_EN.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int  CW      = CLKDIV_DEF_CW,
   parameter int  DEF_DIV = CLKDIV_DEF_DIV,
   parameter type cfg_t   = clkdiv_cfg_t
) (
   input  logic mCLK,
   input  logic reset,
   input  logic wr,
   input  cfg_t wr_cfg,
   input  logic en,
`ifdef CLKDIV_SYNC_ALIGN_EN
   input  logic sync,
`endif
   output logic clk_out,
   output logic tick
);

   localparam cfg_t DEF_CFG = '{div: CW'(DEF_DIV), high: CW'(clkdiv_def_high(DEF_DIV))};

   cfg_t          act_q, act_d;
   cfg_t          pend_q, pend_d;
   cfg_t          cur;
   logic          pend_vld_q, pend_vld_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q;
   logic          clk_q, clk_d;
   logic          tick_q, tick_d;
   logic          restart;

   always_comb begin
      restart = !run_q;
`ifdef CLKDIV_SYNC_ALIGN_EN
      restart = restart || sync;
`endif
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      cur        = act_q;

      if (!en) begin
         cnt_d      = '0;
         clk_d      = 1'b0;
         if (pend_vld_q)
            act_d = pend_q;
         pend_vld_d = 1'b0;
         if (wr)
            act_d = wr_cfg;
      end else begin
         // A first-enabled edge (or sync) behaves exactly like a wrap: cnt
         // restarts at 0, so clk_out rises with no extra latency.
         if (restart || (cnt_q == act_q.div - CW'(1))) begin
            cnt_d = '0;
            if (pend_vld_q) begin
               cur        = pend_q;
               pend_vld_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         act_d  = cur;
         clk_d  = (cnt_d < cur.high);
         tick_d = (cnt_d == cur.div - CW'(1));
         if (wr) begin
            pend_d     = wr_cfg;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge mCLK) begin
      if (reset) begin
         act_q      <= DEF_CFG;
         pend_q     <= DEF_CFG;
         pend_vld_q <= 1'b0;
         cnt_q      <= '0;
         run_q      <= 1'b0;
         clk_q      <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         act_q      <= act_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         run_q      <= en;
         clk_q      <= clk_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_nch.sv
// NCH independent programmable clock dividers with write validation.
// Define CLKDIV_SYNC_ALIGN_EN to add the sync input for phase alignment.
module clock_divider_nch
   import clkdiv_pkg::*;
#(
   parameter int  NCH     = CLKDIV_DEF_NCH,
   parameter int  CW      = CLKDIV_DEF_CW,
   parameter int  DEF_DIV = CLKDIV_DEF_DIV,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           mCLK,
   input  logic           reset,
   input  logic           cfg_wr,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   input  logic [CW-1:0]  cfg_high,
   input  logic [NCH-1:0] ch_en,
`ifdef CLKDIV_SYNC_ALIGN_EN
   input  logic           sync,
`endif
   output logic           cfg_err,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] tick
);

   typedef struct packed {
      logic [CW-1:0] div;
      logic [CW-1:0] high;
   } ch_cfg_t;

   ch_cfg_t wr_cfg;
   logic    cfg_ok;
   logic    cfg_err_q, cfg_err_d;

   assign wr_cfg = '{div: cfg_div, high: cfg_high};

   always_comb begin
      cfg_ok    = (cfg_div >= CW'(2)) && (cfg_high != '0) && (cfg_high < cfg_div)
                  && (32'(cfg_ch) < 32'(NCH));
      cfg_err_d = cfg_wr && !cfg_ok;
   end

   always_ff @(posedge mCLK) begin
      if (reset)
         cfg_err_q <= 1'b0;
      else
         cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         clkdiv_channel #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV),
            .cfg_t   (ch_cfg_t)
         ) u_ch (
            .mCLK    (mCLK),
            .reset   (reset),
            .wr      (cfg_wr && cfg_ok && (cfg_ch == CHW'(gi))),
            .wr_cfg  (wr_cfg),
            .en      (ch_en[gi]),
`ifdef CLKDIV_SYNC_ALIGN_EN
            .sync    (sync),
`endif
            .clk_out (clk_out[gi]),
            .tick    (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_nch.sv
// Scoreboard bench for clock_divider_nch: a period-level reference model
// queues the expected outputs of every edge, a monitor compares them.
module tb_clock_divider_nch;

   // Three channels leave a 2-bit channel code (3) that is out of range.
   localparam int NCH     = 3;
   localparam int CW      = 16;
   localparam int DEF_DIV = 2;
   localparam int CHW     = 2;

   typedef struct packed {
      logic [NCH-1:0] clk;
      logic [NCH-1:0] tk;
      logic           err;
   } exp_t;

   logic           mCLK     = 1'b0;
   logic           reset    = 1'b1;
   logic           cfg_wr   = 1'b0;
   logic [CHW-1:0] cfg_ch   = '0;
   logic [CW-1:0]  cfg_div  = '0;
   logic [CW-1:0]  cfg_high = '0;
   logic [NCH-1:0] ch_en    = '0;
   logic           cfg_err;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;
`ifdef CLKDIV_SYNC_ALIGN_EN
   logic           sync     = 1'b0;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   clock_divider_nch #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
      .mCLK     (mCLK),
      .reset    (reset),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .ch_en    (ch_en),
`ifdef CLKDIV_SYNC_ALIGN_EN
      .sync     (sync),
`endif
      .cfg_err  (cfg_err),
      .clk_out  (clk_out),
      .tick     (tick)
   );

   always #5 mCLK = ~mCLK;

   // Reference model: each running channel remembers the edge its current
   // period began; outputs follow from the elapsed cycle count in that period.
   int m_div[NCH], m_high[NCH], p_div[NCH], p_high[NCH], m_start[NCH];
   bit m_run[NCH], m_pend[NCH];
   int edge_n = 0;

   always @(posedge mCLK) begin
      exp_t e;
      bit   ok, w;
      int   k;
      e = '0;
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_div[c]  = DEF_DIV;
            m_high[c] = (DEF_DIV / 2 < 1) ? 1 : DEF_DIV / 2;
            m_pend[c] = 1'b0;
            m_run[c]  = 1'b0;
         end
      end else begin
         ok = (cfg_div >= 2) && (cfg_high != 0) && (cfg_high < cfg_div) && (int'(cfg_ch) < NCH);
         e.err = cfg_wr && !ok;
         for (int c = 0; c < NCH; c++) begin
            w = cfg_wr && ok && (int'(cfg_ch) == c);
            if (!ch_en[c]) begin
               if (m_pend[c]) begin
                  m_div[c]  = p_div[c];
                  m_high[c] = p_high[c];
               end
               m_pend[c] = 1'b0;
               m_run[c]  = 1'b0;
               if (w) begin
                  m_div[c]  = int'(cfg_div);
                  m_high[c] = int'(cfg_high);
               end
            end else begin
               if (!m_run[c]) begin
                  m_run[c]   = 1'b1;
                  m_start[c] = edge_n;
               end else if (edge_n - m_start[c] == m_div[c]) begin
                  m_start[c] = edge_n;
                  if (m_pend[c]) begin
                     m_div[c]  = p_div[c];
                     m_high[c] = p_high[c];
                     m_pend[c] = 1'b0;
                  end
               end
               if (w) begin
                  p_div[c]  = int'(cfg_div);
                  p_high[c] = int'(cfg_high);
                  m_pend[c] = 1'b1;
               end
               k = edge_n - m_start[c];
               e.clk[c] = (k < m_high[c]);
               e.tk[c]  = (k == m_div[c] - 1);
            end
         end
      end
      sb_q.push_back(e);
      edge_n++;
   end

   always @(negedge mCLK) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_vec++;
         if (clk_out !== e.clk || tick !== e.tk || cfg_err !== e.err) begin
            n_err++;
            if (n_err <= 40)
               $display("FAIL vec %0d: clk_out=%b tick=%b cfg_err=%b, expected clk_out=%b tick=%b cfg_err=%b",
                        n_vec, clk_out, tick, cfg_err, e.clk, e.tk, e.err);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge mCLK);
         #1;
      end
   endtask

   task automatic do_wr(input int ch, input int d, input int h);
      cfg_wr   = 1'b1;
      cfg_ch   = CHW'(ch);
      cfg_div  = CW'(d);
      cfg_high = CW'(h);
      step(1);
      cfg_wr   = 1'b0;
   endtask

   initial begin
      int hi, tk, idx;
      step(3);
      reset = 1'b0;

      // ch0 at 50/25: 500 cycles from the enabling edge hold 10 periods.
      do_wr(0, 50, 25);
      ch_en[0] = 1'b1;
      hi = 0;
      tk = 0;
      @(posedge mCLK);
      for (int i = 0; i < 500; i++) begin
         @(negedge mCLK);
         hi += int'(clk_out[0]);
         tk += int'(tick[0]);
      end
      n_vec += 2;
      if (hi != 250) begin
         n_err++;
         $display("FAIL ch0_high_cycles: got %0d, want 250", hi);
      end
      if (tk != 10) begin
         n_err++;
         $display("FAIL ch0_tick_count: got %0d, want 10", tk);
      end
      step(1);

      // Rejected writes.
      do_wr(1, 1, 1);
      do_wr(1, 4, 0);
      do_wr(1, 4, 4);
      do_wr(3, 4, 2);
      step(2);

      // Mid-period reconfiguration of ch1 at cnt = 3.
      do_wr(1, 10, 5);
      ch_en[1] = 1'b1;
      step(4);
      do_wr(1, 6, 2);
      step(25);

      // Last write wins on ch2.
      do_wr(2, 6, 3);
      ch_en[2] = 1'b1;
      step(2);
      do_wr(2, 8, 4);
      do_wr(2, 12, 6);
      step(30);

      // Reset in mid-period of a div = 20 channel.
      ch_en = '0;
      step(1);
      do_wr(0, 20, 10);
      ch_en[0] = 1'b1;
      step(8);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(10);

      // Randomized traffic.
      ch_en = '1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            idx = int'($urandom_range(0, NCH - 1));
            ch_en[idx] = ~ch_en[idx];
         end
         cfg_wr   = ($urandom_range(0, 3) == 0);
         cfg_ch   = CHW'($urandom_range(0, 3));
         cfg_div  = CW'($urandom_range(0, 12));
         cfg_high = CW'($urandom_range(0, 12));
         reset    = ($urandom_range(0, 299) == 0);
         step(1);
      end
      cfg_wr = 1'b0;
      reset  = 1'b0;
      step(3);

      if (n_vec < 2000) begin
         n_err++;
         $display("FAIL vector_count: got %0d, want at least 2000", n_vec);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
